// File: rtl/switch_snapshot_ctrl.sv
// Switch snapshot controller: syncs switches, debounces confirm, latches one snapshot per press.
// Optional macro SWITCH_CTRL_LIVE_EN exposes live synced switches[7:0] at register 2'b11.
module switch_snapshot_ctrl #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned CNT_W      = 20
) (
   input  logic        switclk,
   input  logic        switrst,
   input  logic [15:0] switch_raw,
   input  logic        confirm_raw,
   input  logic        ctrlcs,
   input  logic [1:0]  ctrladdr,
   input  logic        ctrlread,
   input  logic        ctrlwrite,
   input  logic [7:0]  ctrl_wdata,
   output logic [7:0]  ctrl_rdata,
   output logic        snap_valid,
   output logic        snap_overrun
);

   localparam int unsigned SW_W = 16;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            r_state;
   logic [SW_W-1:0]   r_sw_s1, r_sw_s2;
   logic              r_btn_s1, r_btn_s2;
   logic              r_btn_deb;
   logic [CNT_W-1:0]  r_cnt;
   logic [SW_W-1:0]   r_snapshot;
   logic              r_valid;
   logic              r_overrun;
   logic [7:0]        r_rdata;

   logic              w_rd, w_wr, w_clr_valid, w_clr_ovr, w_cap;
   logic [7:0]        w_live;
   logic [7:0]        w_rd_mux;
   logic              w_unused_wdata;

   assign w_rd        = ctrlcs & ctrlread;
   assign w_wr        = ctrlcs & ctrlwrite;
   assign w_clr_valid = w_rd & (ctrladdr == 2'b10);
   assign w_clr_ovr   = w_wr & (ctrladdr == 2'b01) & ctrl_wdata[1];
   assign w_cap       = (r_state == ST_CAPTURE);
   assign w_unused_wdata = &{ctrl_wdata[7:2], ctrl_wdata[0]};

`ifdef SWITCH_CTRL_LIVE_EN
   assign w_live = r_sw_s2[7:0];
`else
   assign w_live = 8'h00;
`endif

   // Read mux sees pre-update state, so a clearing read returns the old byte
   always_comb begin
      w_rd_mux = 8'h00;
      case (ctrladdr)
         2'b00:   w_rd_mux = r_snapshot[7:0];
         2'b01:   w_rd_mux = {6'b0, r_overrun, r_valid};
         2'b10:   w_rd_mux = r_snapshot[15:8];
         default: w_rd_mux = w_live;
      endcase
   end

   // Two-flop synchronisers and button debounce
   always_ff @(posedge switclk) begin
      if (switrst) begin
         r_sw_s1   <= '0;
         r_sw_s2   <= '0;
         r_btn_s1  <= 1'b0;
         r_btn_s2  <= 1'b0;
         r_btn_deb <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sw_s1  <= switch_raw;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= confirm_raw;
         r_btn_s2 <= r_btn_s1;
         if (r_btn_s2 == r_btn_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_LAST) begin
            r_btn_deb <= ~r_btn_deb;
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Press sequencer, snapshot/status registers and MMIO read data
   always_ff @(posedge switclk) begin
      if (switrst) begin
         r_state    <= ST_IDLE;
         r_snapshot <= '0;
         r_valid    <= 1'b0;
         r_overrun  <= 1'b0;
         r_rdata    <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE:    if (r_btn_deb) r_state <= ST_CAPTURE;
            ST_CAPTURE: r_state <= ST_RELEASE;
            ST_RELEASE: if (!r_btn_deb) r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase

         // A clearing read in the capture cycle drops the capture entirely
         if (w_clr_valid) begin
            r_valid <= 1'b0;
         end else if (w_cap && !r_valid) begin
            r_snapshot <= r_sw_s2;
            r_valid    <= 1'b1;
         end

         if (w_cap && r_valid && !w_clr_valid) begin
            r_overrun <= 1'b1;
         end else if (w_clr_ovr) begin
            r_overrun <= 1'b0;
         end

         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   assign ctrl_rdata   = r_rdata;
   assign snap_valid   = r_valid;
   assign snap_overrun = r_overrun;

endmodule

// File: tb/tb_switch_snapshot_ctrl.sv
// Directed bench for switch_snapshot_ctrl with DEB_CYCLES=4: register tables plus press sequences.
module tb_switch_snapshot_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic        btn;
   logic        cs, rd, wr;
   logic [1:0]  addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        valid, ovr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic       exp_v;
      logic       exp_o;
   } vec_t;

   vec_t t1[4];
   vec_t t3[7];

   switch_snapshot_ctrl #(.DEB_CYCLES(4), .CNT_W(20)) dut (
      .switclk     (clk),
      .switrst     (rst),
      .switch_raw  (sw),
      .confirm_raw (btn),
      .ctrlcs      (cs),
      .ctrladdr    (addr),
      .ctrlread    (rd),
      .ctrlwrite   (wr),
      .ctrl_wdata  (wdata),
      .ctrl_rdata  (rdata),
      .snap_valid  (valid),
      .snap_overrun(ovr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; rd = r; wr = w; addr = a; wdata = d;
      tick();
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'b00; wdata = 8'h00;
   endtask

   task automatic apply(input string name, input vec_t v);
      access(v.rd, v.wr, v.addr, v.wdata);
      check({name, " rdata"}, 16'(rdata), 16'(v.exp_rd));
      check({name, " valid"}, 16'(valid), 16'(v.exp_v));
      check({name, " overrun"}, 16'(ovr), 16'(v.exp_o));
   endtask

   // Full press: long enough to debounce, capture, release and return to idle
   task automatic press(input logic [15:0] s);
      sw = s;
      btn = 1'b1;
      repeat (12) tick();
      btn = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t1[0] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h5A, 1'b1, 1'b0};
      t1[1] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h01, 1'b1, 1'b0};
      t1[2] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'hA5, 1'b0, 1'b0};
      t1[3] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 1'b0};

      t3[0] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h03, 1'b1, 1'b1};
      t3[1] = '{1'b0, 1'b1, 2'b01, 8'h02, 8'h03, 1'b1, 1'b0};
      t3[2] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h01, 1'b1, 1'b0};
      t3[3] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'h34, 1'b1, 1'b0};
      t3[4] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'h12, 1'b0, 1'b0};
      t3[5] = '{1'b1, 1'b1, 2'b01, 8'h02, 8'h00, 1'b0, 1'b0};
      t3[6] = '{1'b0, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0, 1'b0};

      rst = 1'b1; sw = 16'h0000; btn = 1'b0;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'b00; wdata = 8'h00;
      repeat (3) tick();
      check("reset rdata", 16'(rdata), 16'h0000);
      check("reset valid", 16'(valid), 16'h0000);
      check("reset overrun", 16'(ovr), 16'h0000);
      rst = 1'b0;
      tick();

      // 1: single press, then read sequence
      sw = 16'hA55A;
      btn = 1'b1;
      repeat (10) tick();
      btn = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 4; i++) apply($sformatf("t1[%0d]", i), t1[i]);

      // 2: bounce with runs shorter than the debounce window
      sw = 16'hFFFF;
      btn = 1'b1; repeat (2) tick();
      btn = 1'b0; repeat (2) tick();
      btn = 1'b1; repeat (3) tick();
      btn = 1'b0; repeat (12) tick();
      check("bounce valid", 16'(valid), 16'h0000);
      access(1'b1, 1'b0, 2'b00, 8'h00);
      check("bounce snapshot lo", 16'(rdata), 16'h005A);

      // 3: two presses without a read give overrun and keep the first value
      press(16'h1234);
      press(16'h5678);
      for (int i = 0; i < 7; i++) apply($sformatf("t3[%0d]", i), t3[i]);

      // 4: clearing high-byte read lands exactly on the capture cycle
      press(16'hBEEF);
      check("t4 pre valid", 16'(valid), 16'h0001);
      sw = 16'h1111;
      btn = 1'b1;
      repeat (7) tick();
      access(1'b1, 1'b0, 2'b10, 8'h00);
      check("t4 old hi byte", 16'(rdata), 16'h00BE);
      repeat (4) tick();
      btn = 1'b0;
      repeat (10) tick();
      check("t4 valid", 16'(valid), 16'h0000);
      check("t4 overrun", 16'(ovr), 16'h0000);
      access(1'b1, 1'b0, 2'b00, 8'h00);
      check("t4 snapshot kept", 16'(rdata), 16'h00EF);

      // 5: reset while held in release, then one fresh capture
      sw = 16'h0F0F;
      btn = 1'b1;
      repeat (12) tick();
      check("t5 pre-reset valid", 16'(valid), 16'h0001);
      rst = 1'b1;
      repeat (2) tick();
      check("t5 reset rdata", 16'(rdata), 16'h0000);
      check("t5 reset valid", 16'(valid), 16'h0000);
      check("t5 reset overrun", 16'(ovr), 16'h0000);
      rst = 1'b0;
      repeat (12) tick();
      btn = 1'b0;
      repeat (10) tick();
      check("t5 valid", 16'(valid), 16'h0001);
      check("t5 overrun", 16'(ovr), 16'h0000);
      access(1'b1, 1'b0, 2'b00, 8'h00);
      check("t5 snapshot lo", 16'(rdata), 16'h000F);

      // 6: live switch register
      sw = 16'h00C3;
      repeat (3) tick();
      access(1'b1, 1'b0, 2'b11, 8'h00);
`ifdef SWITCH_CTRL_LIVE_EN
      check("t6 live", 16'(rdata), 16'h00C3);
`else
      check("t6 live", 16'(rdata), 16'h0000);
`endif
      check("t6 valid", 16'(valid), 16'h0001);
      access(1'b1, 1'b0, 2'b01, 8'h00);
      check("t6 status", 16'(rdata), 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
